// File: rtl/retro_mem_pkg.sv
// Shared types for the RetroMemoryPort copy/fill engine: FSM state encoding
// and the byte write-enable mask helper.
package retro_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RWAIT,
        WRITE,
        DONE
    } copy_state_t;

    localparam int MaxMaskBytes = 64;

    function automatic logic [MaxMaskBytes-1:0] write_mask(input int bytes);
        logic [MaxMaskBytes-1:0] m;
        m = '0;
        for (int i = 0; i < MaxMaskBytes; i++) begin
            if (i < bytes) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/retro_mem_copy_engine.sv
// Block copy / block fill master for a single RetroMemoryPort target.
// Copy moves one word per read-then-write pair; fill streams constant writes.
module retro_mem_copy_engine
    import retro_mem_pkg::*;
#(
    parameter int AddressBusWidth = 12,
    parameter int DataBusWidth    = 1,
    parameter int LengthWidth     = 13
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic                         Fill,
    input  logic [AddressBusWidth-1:0]   SrcAddr,
    input  logic [AddressBusWidth-1:0]   DstAddr,
    input  logic [LengthWidth-1:0]       Length,
    input  logic [DataBusWidth*8-1:0]    FillValue,
    input  logic                         Abort,
    output logic                         Busy,
    output logic                         Done,
    output logic                         MemAccess,
    output logic [DataBusWidth-1:0]      MemWrite,
    output logic [AddressBusWidth-1:0]   MemAddress,
    output logic [DataBusWidth*8-1:0]    MemDin,
    input  logic [DataBusWidth*8-1:0]    MemDout,
    input  logic                         MemReady,
    input  logic                         MemDataReady
);

    localparam int DataWidth = DataBusWidth * 8;
    localparam logic [DataBusWidth-1:0]    WriteMask = DataBusWidth'(write_mask(DataBusWidth));
    localparam logic [AddressBusWidth-1:0] AddrStep  = AddressBusWidth'(1);
    localparam logic [LengthWidth-1:0]     LenOne    = LengthWidth'(1);

    copy_state_t                 state, state_next;
    logic                        fill_mode, fill_mode_next;
    logic [AddressBusWidth-1:0]  src, src_next;
    logic [AddressBusWidth-1:0]  dst, dst_next;
    logic [LengthWidth-1:0]      remaining, remaining_next;
    logic [DataWidth-1:0]        hold, hold_next;
    logic [DataWidth-1:0]        fill_value, fill_value_next;
    logic                        busy_next, done_next, access_next;
    logic [DataBusWidth-1:0]     write_next;
    logic [AddressBusWidth-1:0]  address_next;
    logic                        accepted;

    assign accepted = MemAccess && MemReady;

    // Both sources are flops that only change while no write is pending.
    assign MemDin = fill_mode ? fill_value : hold;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            fill_mode  <= 1'b0;
            src        <= '0;
            dst        <= '0;
            remaining  <= '0;
            hold       <= '0;
            fill_value <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            MemAccess  <= 1'b0;
            MemWrite   <= '0;
            MemAddress <= '0;
        end else begin
            state      <= state_next;
            fill_mode  <= fill_mode_next;
            src        <= src_next;
            dst        <= dst_next;
            remaining  <= remaining_next;
            hold       <= hold_next;
            fill_value <= fill_value_next;
            Busy       <= busy_next;
            Done       <= done_next;
            MemAccess  <= access_next;
            MemWrite   <= write_next;
            MemAddress <= address_next;
        end
    end

    always_comb begin
        state_next      = state;
        fill_mode_next  = fill_mode;
        src_next        = src;
        dst_next        = dst;
        remaining_next  = remaining;
        hold_next       = hold;
        fill_value_next = fill_value;
        busy_next       = Busy;
        done_next       = 1'b0;
        access_next     = MemAccess;
        write_next      = MemWrite;
        address_next    = MemAddress;

        unique case (state)
            IDLE: begin
                if (Start && !Abort) begin
                    fill_mode_next  = Fill;
                    src_next        = SrcAddr;
                    dst_next        = DstAddr;
                    remaining_next  = Length;
                    fill_value_next = FillValue;
                    busy_next       = 1'b1;
                    if (Length == '0) begin
                        state_next = DONE;
                    end else if (Fill) begin
                        state_next   = WRITE;
                        access_next  = 1'b1;
                        write_next   = WriteMask;
                        address_next = DstAddr;
                    end else begin
                        state_next   = READ;
                        access_next  = 1'b1;
                        write_next   = '0;
                        address_next = SrcAddr;
                    end
                end
            end
            READ: begin
                // A read accepted without a data beat stays here and is reissued.
                if (accepted && MemDataReady) begin
                    state_next  = RWAIT;
                    access_next = 1'b0;
                end
            end
            RWAIT: begin
                hold_next    = MemDout;
                state_next   = WRITE;
                access_next  = 1'b1;
                write_next   = WriteMask;
                address_next = dst;
            end
            WRITE: begin
                if (accepted) begin
                    src_next       = src + AddrStep;
                    dst_next       = dst + AddrStep;
                    remaining_next = remaining - LenOne;
                    if (remaining == LenOne) begin
                        state_next  = DONE;
                        access_next = 1'b0;
                        write_next  = '0;
                    end else if (fill_mode) begin
                        address_next = dst + AddrStep;
                    end else begin
                        state_next   = READ;
                        write_next   = '0;
                        address_next = src + AddrStep;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                done_next  = 1'b1;
                busy_next  = 1'b0;
            end
            default: state_next = IDLE;
        endcase

        // Counters above still advance if a write is accepted on the abort edge.
        if (Abort && state != IDLE) begin
            state_next  = IDLE;
            access_next = 1'b0;
            write_next  = '0;
            busy_next   = 1'b0;
            done_next   = 1'b0;
        end
    end

endmodule

// File: tb/tb_retro_mem_copy_engine.sv
// Bench for retro_mem_copy_engine: a one-cycle BRAM target, a transaction-level
// model of the expected access stream and memory image, and directed commands.
module tb_retro_mem_copy_engine;

    typedef struct {
        bit         wr;
        logic [11:0] addr;
        logic [7:0]  data;
    } mem_op_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start, Fill, Abort;
    logic [11:0] SrcAddr, DstAddr;
    logic [12:0] Length;
    logic [7:0]  FillValue;
    logic        Busy, Done, MemAccess;
    logic [0:0]  MemWrite;
    logic [11:0] MemAddress;
    logic [7:0]  MemDin;
    logic [7:0]  MemDout = 8'h00;
    logic        MemReady, MemDataReady;

    logic        pl_we;
    logic [11:0] pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  bram   [0:4095] = '{default: 8'h00};
    logic [7:0]  shadow [0:4095] = '{default: 8'h00};

    mem_op_t     exp_q[$];
    bit          done_armed;
    bit          prev_valid;
    logic [21:0] prev_bus;
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;

    retro_mem_copy_engine dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Fill         (Fill),
        .SrcAddr      (SrcAddr),
        .DstAddr      (DstAddr),
        .Length       (Length),
        .FillValue    (FillValue),
        .Abort        (Abort),
        .Busy         (Busy),
        .Done         (Done),
        .MemAccess    (MemAccess),
        .MemWrite     (MemWrite),
        .MemAddress   (MemAddress),
        .MemDin       (MemDin),
        .MemDout      (MemDout),
        .MemReady     (MemReady),
        .MemDataReady (MemDataReady)
    );

    // One-cycle BRAM target: read data appears on the edge after acceptance.
    always @(posedge Clk) begin
        if (pl_we) bram[pl_addr] <= pl_data;
        else if (MemAccess && MemReady) begin
            if (MemWrite != 1'b0) bram[MemAddress] <= MemDin;
            else MemDout <= bram[MemAddress];
        end
    end
    assign MemDataReady = MemAccess && MemReady && (MemWrite == 1'b0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        mem_op_t e;
        if (Reset) begin
            prev_valid = 1'b0;
            return;
        end
        if (prev_valid)
            chk("stall_hold", 32'({MemAccess, MemWrite, MemAddress, MemDin}), 32'(prev_bus));
        if (MemAccess && MemReady) begin
            chk("access_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("access_kind", 32'(MemWrite), e.wr ? 32'd1 : 32'd0);
                chk("access_addr", 32'(MemAddress), 32'(e.addr));
                if (e.wr) begin
                    chk("write_data", 32'(MemDin), 32'(e.data));
                    shadow[e.addr] = e.data;
                end
            end
        end
        if (Done) begin
            chk("done_expected", 32'({done_armed, Busy, exp_q.size() == 0}), 32'b101);
            done_armed = 1'b0;
        end
        prev_valid = MemAccess && !MemReady && !Abort;
        prev_bus   = {MemAccess, MemWrite, MemAddress, MemDin};
    endtask

    // Ascending word-by-word transfer evaluated on a scratch copy of memory.
    task automatic expect_cmd(input bit fill, input logic [11:0] src, input logic [11:0] dst,
                              input int len, input logic [7:0] val);
        logic [7:0] tmp [0:4095];
        logic [11:0] s, d;
        logic [7:0]  w;
        tmp = shadow;
        for (int i = 0; i < len; i++) begin
            s = src + 12'(i);
            d = dst + 12'(i);
            if (fill) w = val;
            else begin
                w = tmp[s];
                exp_q.push_back('{wr: 1'b0, addr: s, data: 8'h00});
            end
            tmp[d] = w;
            exp_q.push_back('{wr: 1'b1, addr: d, data: w});
        end
        done_armed = 1'b1;
    endtask

    task automatic drive_start(input bit fill, input logic [11:0] src, input logic [11:0] dst,
                               input int len, input logic [7:0] val);
        Fill      = fill;
        SrcAddr   = src;
        DstAddr   = dst;
        Length    = 13'(len);
        FillValue = val;
        Start     = 1'b1;
    endtask

    task automatic run_cmd(input string name, input bit fill, input logic [11:0] src,
                           input logic [11:0] dst, input int len, input logic [7:0] val,
                           input int stall, input int exp_cycles);
        int  cycles;
        bit  got;
        expect_cmd(fill, src, dst, len, val);
        drive_start(fill, src, dst, len, val);
        if (stall > 0) MemReady = 1'b0;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < exp_cycles + 20) begin
            @(posedge Clk); #1;
            Start = 1'b0;
            cycles++;
            if (cycles == stall + 1) MemReady = 1'b1;
            if (Done) got = 1'b1;
        end
        MemReady = 1'b1;
        chk({name, "_done_cycle"}, 32'(cycles), 32'(exp_cycles));
        chk({name, "_busy_at_done"}, 32'(Busy), 32'd0);
        @(posedge Clk); #1;
        chk({name, "_done_width"}, 32'(Done), 32'd0);
        chk({name, "_done_seen"}, 32'(done_armed), 32'd0);
        chk({name, "_ops_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        shadow[a] = d;
        @(posedge Clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        int mism;
        fork
            forever begin
                @(negedge Clk);
                compare_cycle();
            end
        join_none

        Reset = 1'b1; Start = 1'b0; Fill = 1'b0; Abort = 1'b0;
        SrcAddr = '0; DstAddr = '0; Length = '0; FillValue = '0;
        MemReady = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        step(2);
        chk("reset_outputs", 32'({Busy, Done, MemAccess, MemWrite, MemAddress, MemDin}), 32'd0);
        Reset = 1'b0;
        step(1);

        preload(12'h000, 8'h11);
        preload(12'h001, 8'h22);
        preload(12'h002, 8'h33);

        run_cmd("fill4", 1'b1, 12'h000, 12'h010, 4, 8'hA5, 0, 6);
        for (int a = 12'h010; a <= 12'h013; a++)
            chk("fill4_bram", 32'(bram[a]), 32'hA5);

        run_cmd("copy3", 1'b0, 12'h000, 12'h100, 3, 8'h00, 0, 11);
        chk("copy3_bram0", 32'(bram[12'h100]), 32'h11);
        chk("copy3_bram1", 32'(bram[12'h101]), 32'h22);
        chk("copy3_bram2", 32'(bram[12'h102]), 32'h33);

        run_cmd("len0", 1'b1, 12'h000, 12'h080, 0, 8'hEE, 0, 2);

        run_cmd("stall", 1'b1, 12'h000, 12'h200, 4, 8'h5A, 5, 11);
        chk("stall_bram_first", 32'(bram[12'h200]), 32'h5A);
        chk("stall_bram_last", 32'(bram[12'h203]), 32'h5A);

        run_cmd("wrap", 1'b1, 12'h000, 12'hFFE, 4, 8'h3C, 0, 6);
        chk("wrap_ffe", 32'(bram[12'hFFE]), 32'h3C);
        chk("wrap_fff", 32'(bram[12'hFFF]), 32'h3C);
        chk("wrap_000", 32'(bram[12'h000]), 32'h3C);
        chk("wrap_001", 32'(bram[12'h001]), 32'h3C);
        chk("wrap_002", 32'(bram[12'h002]), 32'h33);

        // Abort during the second read of an 8-word copy.
        expect_cmd(1'b0, 12'h000, 12'h300, 8, 8'h00);
        drive_start(1'b0, 12'h000, 12'h300, 8, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            @(posedge Clk); #1;
            Start = 1'b0;
        end
        chk("abort_in_read", 32'({MemAccess, MemWrite, MemAddress}), 32'({1'b1, 1'b0, 12'h001}));
        Abort = 1'b1;
        step(1);
        Abort = 1'b0;
        chk("abort_outputs", 32'({MemAccess, MemWrite, Busy, Done}), 32'd0);
        exp_q.delete();
        done_armed = 1'b0;
        step(4);
        chk("abort_word0", 32'(bram[12'h300]), 32'h3C);
        chk("abort_word1", 32'(bram[12'h301]), 32'h00);
        run_cmd("after_abort", 1'b1, 12'h000, 12'h400, 2, 8'h77, 0, 4);
        chk("after_abort_bram", 32'(bram[12'h401]), 32'h77);

        // Abort together with Start in IDLE must not launch anything.
        drive_start(1'b1, 12'h000, 12'h480, 2, 8'h44);
        Abort = 1'b1;
        step(1);
        Start = 1'b0; Abort = 1'b0;
        chk("abort_start_idle", 32'({Busy, MemAccess}), 32'd0);
        step(3);
        chk("abort_start_bram", 32'(bram[12'h480]), 32'h00);

        // Reset in the middle of a fill, after two writes have landed.
        expect_cmd(1'b1, 12'h000, 12'h500, 8, 8'h99);
        drive_start(1'b1, 12'h000, 12'h500, 8, 8'h99);
        for (int c = 1; c <= 3; c++) begin
            @(posedge Clk); #1;
            Start = 1'b0;
        end
        Reset = 1'b1;
        #1;
        chk("midreset_outputs", 32'({Busy, Done, MemAccess, MemWrite, MemAddress, MemDin}), 32'd0);
        exp_q.delete();
        done_armed = 1'b0;
        step(2);
        Reset = 1'b0;
        step(1);
        chk("midreset_written", 32'(bram[12'h501]), 32'h99);
        chk("midreset_unwritten", 32'(bram[12'h502]), 32'h00);
        run_cmd("post_reset", 1'b0, 12'h500, 12'h600, 2, 8'h00, 0, 8);
        chk("post_reset_bram", 32'({bram[12'h600], bram[12'h601]}), 32'h9999);

        run_cmd("maxlen", 1'b1, 12'h000, 12'h000, 8191, 8'hE1, 0, 8193);
        chk("maxlen_bram", 32'(bram[12'hFFE]), 32'hE1);

        mism = 0;
        for (int a = 0; a < 4096; a++)
            if (bram[a] !== shadow[a]) mism++;
        chk("mem_image", 32'(mism), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
